// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package debounce_pkg;

  localparam int DEF_W     = 4;
  localparam int DEF_N     = 3;
  localparam int DEF_SYNC  = 2;
  localparam int DEF_PRESC = 1;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser chain, stability counter, debounced level
// and registered rise/fall strobes.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int   N       = DEF_N,
  parameter int   SYNC    = DEF_SYNC,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int            CW   = clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [SYNC-1:0] sync;
  logic [CW-1:0]   cnt;
  logic            s;

  assign s = sync[SYNC-1];

  // NOTE: non-blocking assignments so every register samples pre-edge values;
  // strobes default low each cycle and are only raised on the updating tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= {SYNC{RST_VAL}};
      cnt  <= '0;
      q    <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC-2:0], d};
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        if (s == q) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          q    <= s;
          cnt  <= '0;
          rise <= s;
          fall <= ~s;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign busy = |cnt;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: shared sample-rate prescaler, W independent
// channels and an aggregate busy flag.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int   W       = DEF_W,
  parameter int   N       = DEF_N,
  parameter int   SYNC    = DEF_SYNC,
  parameter int   PRESC   = DEF_PRESC,
  parameter logic RST_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall,
  output logic         busy
);

  logic         tick;
  logic [W-1:0] ch_busy;

  generate
    if (PRESC == 1) begin : g_no_presc
      assign tick = 1'b1;
    end else begin : g_presc
      localparam int            PW      = clog2(PRESC);
      localparam logic [PW-1:0] PC_LAST = PW'(PRESC - 1);
      logic [PW-1:0] pc;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)               pc <= '0;
        else if (pc == PC_LAST) pc <= '0;
        else                    pc <= pc + PW'(1);
      end

      assign tick = (pc == PC_LAST);
    end
  endgenerate

  for (genvar i = 0; i < W; i++) begin : g_ch
    debounce_ch #(
      .N      (N),
      .SYNC   (SYNC),
      .RST_VAL(RST_VAL)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .tick(tick),
      .d   (d[i]),
      .q   (q[i]),
      .rise(rise[i]),
      .fall(fall[i]),
      .busy(ch_busy[i])
    );
  end

  assign busy = |ch_busy;

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: per-cycle vector table with a
// scoreboard queue, plus sequences for async reset, prescaler and N=1.
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] d   = 4'h0;
  logic [3:0] q, rise, fall;
  logic       busy;

  logic [1:0] d1 = 2'b00;
  logic [1:0] q1, rise1, fall1;
  logic       busy1;

  logic [0:0] d2 = 1'b0;
  logic [0:0] q2, rise2, fall2;
  logic       busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_multi #(.W(4), .N(3), .SYNC(2), .PRESC(1), .RST_VAL(1'b0)) u_main (
    .clk(clk), .rst(rst), .d(d), .q(q), .rise(rise), .fall(fall), .busy(busy)
  );

  debounce_multi #(.W(2), .N(3), .SYNC(2), .PRESC(4), .RST_VAL(1'b0)) u_presc (
    .clk(clk), .rst(rst), .d(d1), .q(q1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  debounce_multi #(.W(1), .N(1), .SYNC(2), .PRESC(1), .RST_VAL(1'b0)) u_n1 (
    .clk(clk), .rst(rst), .d(d2), .q(q2), .rise(rise2), .fall(fall2), .busy(busy2)
  );

  typedef struct {
    logic       rst;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] dv, input logic [3:0] qv,
                     input logic [3:0] rv, input logic [3:0] fv, input logic bv);
    vecs.push_back(vec_t'{r, dv, qv, rv, fv, bv});
  endtask

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n;
    logic flag;
    logic seen;

    // Expected values are the outputs just after the edge that follows the
    // row's inputs (N=3, SYNC=2, PRESC=1).
    add(0, 4'hF, 4'h0, 4'h0, 4'h0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(0, 4'h5, 4'h0, 4'h0, 4'h0, 0);
    add(0, 4'hA, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'hF, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'hF, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'hF, 4'h0, 4'h0, 4'h0, 1);
    add(1, 4'hF, 4'h0, 4'h0, 4'h0, 1);
    add(1, 4'hF, 4'hF, 4'hF, 4'h0, 0);
    add(1, 4'hF, 4'hF, 4'h0, 4'h0, 0);
    // two-cycle glitch on channel 0 is rejected
    add(1, 4'hE, 4'hF, 4'h0, 4'h0, 0);
    add(1, 4'hE, 4'hF, 4'h0, 4'h0, 0);
    add(1, 4'hF, 4'hF, 4'h0, 4'h0, 1);
    add(1, 4'hF, 4'hF, 4'h0, 4'h0, 1);
    add(1, 4'hF, 4'hF, 4'h0, 4'h0, 0);
    add(1, 4'hF, 4'hF, 4'h0, 4'h0, 0);
    // five-cycle low on channel 0 gets through, then returns high
    add(1, 4'hE, 4'hF, 4'h0, 4'h0, 0);
    add(1, 4'hE, 4'hF, 4'h0, 4'h0, 0);
    add(1, 4'hE, 4'hF, 4'h0, 4'h0, 1);
    add(1, 4'hE, 4'hF, 4'h0, 4'h0, 1);
    add(1, 4'hE, 4'hE, 4'h0, 4'h1, 0);
    add(1, 4'hF, 4'hE, 4'h0, 4'h0, 0);
    add(1, 4'hF, 4'hE, 4'h0, 4'h0, 0);
    add(1, 4'hF, 4'hE, 4'h0, 4'h0, 1);
    add(1, 4'hF, 4'hE, 4'h0, 4'h0, 1);
    add(1, 4'hF, 4'hF, 4'h1, 4'h0, 0);
    add(1, 4'hF, 4'hF, 4'h0, 4'h0, 0);
    // settle to 0101, then swap to 1010: simultaneous rise and fall
    add(1, 4'h5, 4'hF, 4'h0, 4'h0, 0);
    add(1, 4'h5, 4'hF, 4'h0, 4'h0, 0);
    add(1, 4'h5, 4'hF, 4'h0, 4'h0, 1);
    add(1, 4'h5, 4'hF, 4'h0, 4'h0, 1);
    add(1, 4'h5, 4'h5, 4'h0, 4'hA, 0);
    add(1, 4'h5, 4'h5, 4'h0, 4'h0, 0);
    add(1, 4'hA, 4'h5, 4'h0, 4'h0, 0);
    add(1, 4'hA, 4'h5, 4'h0, 4'h0, 0);
    add(1, 4'hA, 4'h5, 4'h0, 4'h0, 1);
    add(1, 4'hA, 4'h5, 4'h0, 4'h0, 1);
    add(1, 4'hA, 4'hA, 4'hA, 4'h5, 0);
    add(1, 4'hA, 4'hA, 4'h0, 4'h0, 0);
    // chatter on channel 3 only
    add(1, 4'h2, 4'hA, 4'h0, 4'h0, 0);
    add(1, 4'h2, 4'hA, 4'h0, 4'h0, 0);
    add(1, 4'hA, 4'hA, 4'h0, 4'h0, 1);
    add(1, 4'h2, 4'hA, 4'h0, 4'h0, 1);
    add(1, 4'hA, 4'hA, 4'h0, 4'h0, 0);
    add(1, 4'hA, 4'hA, 4'h0, 4'h0, 1);
    add(1, 4'hA, 4'hA, 4'h0, 4'h0, 0);
    add(1, 4'hA, 4'hA, 4'h0, 4'h0, 0);
    // start a count on channels 1 and 3, to be cut by reset at cnt=2
    add(1, 4'h0, 4'hA, 4'h0, 4'h0, 0);
    add(1, 4'h0, 4'hA, 4'h0, 4'h0, 0);
    add(1, 4'h0, 4'hA, 4'h0, 4'h0, 1);
    add(1, 4'h0, 4'hA, 4'h0, 4'h0, 1);

    tick_edge();
    check("reset_q_initial", q, 4'h0);
    check("reset_busy_initial", busy, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      d   = vecs[i].d;
      sb.push_back(exp_t'{vecs[i].q, vecs[i].rise, vecs[i].fall, vecs[i].busy});
      tick_edge();
      e = sb.pop_front();
      check($sformatf("vec%0d_q", i), q, e.q);
      check($sformatf("vec%0d_rise", i), rise, e.rise);
      check($sformatf("vec%0d_fall", i), fall, e.fall);
      check($sformatf("vec%0d_busy", i), busy, e.busy);
    end

    // Asynchronous reset mid-count: visible before the next edge.
    rst = 1'b0;
    #2;
    check("async_rst_q", q, 4'h0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_strobes", {rise, fall}, 8'h00);
    tick_edge();
    d   = 4'hF;
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick_edge();
      check($sformatf("post_rst_hold%0d_q", k), q, 4'h0);
    end
    check("post_rst_busy", busy, 1'b1);
    tick_edge();
    check("post_rst_q", q, 4'hF);
    check("post_rst_rise", rise, 4'hF);
    tick_edge();
    check("post_rst_rise_clear", rise, 4'h0);

    // Prescaler, PRESC=4, N=3: reset release aligns the tick phase
    // (ticks on the 4th, 8th, 12th edge after release).
    rst = 1'b0;
    d1  = 2'b00;
    tick_edge();
    rst = 1'b1;
    d1  = 2'b01;
    n   = 0;
    while (n < 40 && q1[0] !== 1'b1) begin
      tick_edge();
      n++;
    end
    check("presc_latency_edges", n, 12);
    check("presc_rise", rise1, 2'b01);
    check("presc_other_ch", q1[1], 1'b0);

    // 7-cycle low pulse spans at most two ticks and must be rejected.
    d1[0] = 1'b0;
    for (int k = 0; k < 7; k++) tick_edge();
    d1[0] = 1'b1;
    flag = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick_edge();
      if (q1[0] !== 1'b1 || fall1[0] !== 1'b0) flag = 1'b1;
      if (busy1) seen = 1'b1;
    end
    check("presc_pulse_rejected", flag, 1'b0);
    check("presc_pulse_busy_seen", seen, 1'b1);

    // Steady change at an arbitrary tick phase: 2 sync edges, 1..4 edges to
    // the first tick, then two more ticks.
    tick_edge();
    d1[0] = 1'b0;
    n     = 0;
    while (n < 40 && q1[0] !== 1'b0) begin
      tick_edge();
      n++;
    end
    check("presc_phase_latency_in_range", (n >= 11 && n <= 14), 1'b1);
    check("presc_phase_fall", fall1, 2'b01);

    // N=1: q follows the synchronised input on the next tick.
    d2 = 1'b1;
    tick_edge();
    check("n1_edge1_q", q2, 1'b0);
    tick_edge();
    check("n1_edge2_q", q2, 1'b0);
    tick_edge();
    check("n1_edge3_q", q2, 1'b1);
    check("n1_edge3_rise", rise2, 1'b1);
    check("n1_busy", busy2, 1'b0);
    tick_edge();
    check("n1_rise_clear", rise2, 1'b0);
    d2 = 1'b0;
    tick_edge();
    tick_edge();
    tick_edge();
    check("n1_fall_q", q2, 1'b0);
    check("n1_fall", {rise2, fall2}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
